inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory interface. Owns the PC, drives the
//  fetch address to the combinational instruction memory and captures the
//  returned word. Buffers {pc, inst} pairs in a small FIFO and hands them to
//  decode with a valid/ready handshake. Accepts branch redirects from execute.
// PARAMETERS
//  DEPTH      2            fetch-queue entries (power of two, >=2)
//  RESET_PC   32'h0        PC loaded on reset
//  IMEM_BYTES 1024         instruction memory size in bytes; last legal PC = IMEM_BYTES-4
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  imem_pc      out  32  fetch byte address to instruction memory (= PC register)
//  imem_inst    in   32  instruction word returned combinationally for imem_pc
//  redirect     in   1   taken branch/jump from execute; one-cycle pulse
//  redirect_pc  in   32  redirect target byte address
//  dec_valid    out  1   head entry valid to decode
//  dec_ready    in   1   decode accepts head entry
//  dec_pc       out  32  PC of head entry
//  dec_inst     out  32  instruction of head entry
//  q_count      out  $clog2(DEPTH)+1  current queue occupancy
//  misalign_err out  1   one-cycle pulse: last redirect target had [1:0]!=0
//  fetch_fault  out  1   sticky: PC beyond IMEM_BYTES-4, fetching halted
// BEHAVIOUR
//  - Reset (async, active-high): PC=RESET_PC, queue empty, q_count=0,
//    dec_valid=0, dec_pc=0, dec_inst=0, misalign_err=0, fetch_fault=0.
//  - pop  = dec_valid & dec_ready.
//  - dec_valid = (q_count!=0) & ~redirect (head killed combinationally on redirect).
//  - push = ~redirect & ~fetch_fault & (PC<=IMEM_BYTES-4) & (q_count<DEPTH | pop).
//    Push writes {PC, imem_inst} at tail; PC<=PC+4 on the same edge. Without push, PC holds.
//  - Full queue with simultaneous pop: push and pop both happen, q_count unchanged.
//  - Latency: imem_pc to dec_valid = 1 cycle; sustained 1 instr/cycle while dec_ready=1.
//  - Redirect (highest priority): on the edge, queue flushed (q_count=0, no push,
//    pop ignored), PC<={redirect_pc[31:2],2'b00}, fetch_fault cleared,
//    misalign_err<=|redirect_pc[1:0] for one cycle.
//  - Address bound: if PC>IMEM_BYTES-4 and no redirect, no push and
//    fetch_fault<=1. fetch_fault stays 1 until redirect or reset; entries already
//    queued still drain normally.
//  - PC+4 is 32-bit modulo; wrap past 32'hFFFFFFFC is covered by the fault rule.
//  - Reset mid-stream: all state returns to reset values immediately, regardless of clk.
//  - dec_pc/dec_inst present the head entry. When the queue is empty they hold
//    the last value; consumers must qualify them with dec_valid.
// STRUCTURE
//  - Shared package fetch_pkg: RESET_PC default, IMEM_BYTES default, INSN_NOP=32'h00000013,
//    fetch_entry_t struct {pc[31:0], inst[31:0]}.
//  - Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t
//    with wr_en/rd_en/flush, count, wrap-around rd/wr pointers. Flush has priority.
//  - Top holds PC register, push/pop logic, bound check, misalign/fault flags.
// TESTING
//  1 Reset then dec_ready=1, memory preloaded: dec_pc sequence 0,4,8,... one per cycle
//    from cycle 1, and dec_inst matches the memory word at each PC.
//  2 dec_ready=0 for 5 cycles: q_count saturates at 2, imem_pc stops at 8.
//    Release: entries PC=0 and PC=4 delivered in order, no loss or duplicate.
//  3 Queue full plus redirect to 0x24 in the same cycle as dec_ready=1:
//    dec_valid=0 that cycle, next cycle q_count=0, imem_pc=0x24, then dec_pc=0x24.
//  4 redirect_pc=0x1E: imem_pc=0x1C next cycle, misalign_err high exactly one cycle.
//  5 Redirect to IMEM_BYTES-4 (0x3FC): one entry delivered, then fetch_fault=1 and
//    imem_pc holds 0x400. Redirect to 0: fetch_fault clears and fetch resumes.
//  6 Assert reset asynchronously mid-stream with a full queue: q_count, dec_valid
//    and fetch_fault drop to 0 without a clock edge, and imem_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int          IMEM_BYTES_DEFAULT = 1024;
    localparam logic [31:0] INSN_NOP           = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit boundary: imem request/response, redirect from execute, decode handshake, status.
interface inst_fetch_unit_if #(
    parameter int DEPTH = 2
);
    logic [31:0]              imem_pc;
    logic [31:0]              imem_inst;
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic                     dec_valid;
    logic                     dec_ready;
    logic [31:0]              dec_pc;
    logic [31:0]              dec_inst;
    logic [$clog2(DEPTH):0]   q_count;
    logic                     misalign_err;
    logic                     fetch_fault;

    modport master (
        output imem_pc,
        input  imem_inst,
        input  redirect,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_pc,
        output dec_inst,
        output q_count,
        output misalign_err,
        output fetch_fault
    );

    modport slave (
        input  imem_pc,
        output imem_inst,
        output redirect,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_pc,
        input  dec_inst,
        input  q_count,
        input  misalign_err,
        input  fetch_fault
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry fetch queue with wrap-around pointers; flush beats any write or read.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  fetch_entry_t           wr_data,
    input  logic                   rd_en,
    output fetch_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Storage array; no reset needed since occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, queues {pc, inst} pairs for decode, handles redirects and the imem bound.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_unit_if.master bus
);
    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [31:0]   LAST_PC    = 32'(IMEM_BYTES - 4);

    logic [31:0]   r_pc;
    logic          r_fault;
    logic          r_misalign;
    fetch_entry_t  r_last;

    fetch_entry_t  w_head;
    fetch_entry_t  w_wr_data;
    logic [CW-1:0] w_count;
    logic          w_in_range;
    logic          w_nonempty;
    logic          w_dec_valid;
    logic          w_pop;
    logic          w_has_room;
    logic          w_push;

    // Handshake decode: a redirect kills the head and blocks the push in the same cycle.
    always_comb begin
        w_in_range       = (r_pc <= LAST_PC);
        w_nonempty       = (w_count != {CW{1'b0}});
        w_dec_valid      = w_nonempty & ~bus.redirect;
        w_pop            = w_dec_valid & bus.dec_ready;
        w_has_room       = (w_count < FULL_COUNT) | w_pop;
        w_push           = ~bus.redirect & ~r_fault & w_in_range & w_has_room;
        w_wr_data.pc     = r_pc;
        w_wr_data.inst   = bus.imem_inst;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.redirect),
        .wr_en   (w_push),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .count   (w_count)
    );

    // PC, fault/misalign flags and the last delivered entry (shown while the queue is empty).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_misalign <= 1'b0;
            r_last     <= '{pc: 32'h0000_0000, inst: 32'h0000_0000};
        end else if (bus.redirect) begin
            r_pc       <= align_word(bus.redirect_pc);
            r_fault    <= 1'b0;
            r_misalign <= |bus.redirect_pc[1:0];
        end else begin
            r_misalign <= 1'b0;
            if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
            if (!w_in_range) begin
                r_fault <= 1'b1;
            end
            if (w_pop) begin
                r_last <= w_head;
            end
        end
    end

    assign bus.imem_pc      = r_pc;
    assign bus.dec_valid    = w_dec_valid;
    assign bus.dec_pc       = w_nonempty ? w_head.pc   : r_last.pc;
    assign bus.dec_inst     = w_nonempty ? w_head.inst : r_last.inst;
    assign bus.q_count      = w_count;
    assign bus.misalign_err = r_misalign;
    assign bus.fetch_fault  = r_fault;

endmodule
